// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debounce / auto-repeat pulser.
// Also provides the width helper for the shared cycle counter.
package debounce_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } db_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 64;
  localparam int DEF_REPEAT_CYCLES   = 16;
  localparam int DEF_REPEAT_EN       = 1;

  // Counter is sized from the largest interval, with one spare bit so it can saturate.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/debounce_pulser_if.sv
// Signal bundle between a button front end (master) and the debounce pulser (slave).
interface debounce_pulser_if;
  // No valid/ready here: decrement is a single-cycle strobe the consumer must take
  // on the cycle it is high; btn_level is a plain level with no handshake.
  logic btn_in;
  logic enable;
  logic decrement;
  logic btn_level;

  modport master (
    output btn_in,
    output enable,
    input  decrement,
    input  btn_level
  );

  modport slave (
    input  btn_in,
    input  enable,
    output decrement,
    output btn_level
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by async active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/debounce_pulser.sv
// Debounces a raw push button and emits one decrement strobe per accepted press,
// plus optional auto-repeat strobes while the button stays held.
module debounce_pulser
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      btn_in,
  input  logic      enable,
  output logic      decrement,
  output logic      btn_level,
  output db_state_e state_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  db_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_sat_d;
  logic          decrement_q;
  logic          btn_level_q;
  logic          btn_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (btn_in),
    .q_o   (btn_sync)
  );

  assign cnt_sat_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  // Strobe is gated by enable and by its own previous value so it can never stretch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      decrement_q <= 1'b0;
      btn_level_q <= 1'b0;
    end else begin
      decrement_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (btn_sync) begin
            state_q <= ST_DEB_PRESS;
            cnt_q   <= '0;
          end
        end
        ST_DEB_PRESS: begin
          if (!btn_sync) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= ST_PRESSED;
            cnt_q       <= '0;
            btn_level_q <= 1'b1;
            decrement_q <= enable & ~decrement_q;
          end else begin
            cnt_q <= cnt_sat_d;
          end
        end
        ST_PRESSED: begin
          if (!btn_sync) begin
            state_q <= ST_DEB_RELEASE;
            cnt_q   <= '0;
          end else if ((REPEAT_EN != 0) && (cnt_q == HOLD_LAST)) begin
            state_q     <= ST_REPEAT;
            cnt_q       <= '0;
            decrement_q <= enable & ~decrement_q;
          end else begin
            cnt_q <= cnt_sat_d;
          end
        end
        ST_REPEAT: begin
          if (!btn_sync) begin
            state_q <= ST_DEB_RELEASE;
            cnt_q   <= '0;
          end else if (cnt_q == REP_LAST) begin
            cnt_q       <= '0;
            decrement_q <= enable & ~decrement_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DEB_RELEASE: begin
          // A bounce back high restarts the hold interval rather than resuming repeat.
          if (btn_sync) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_sat_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign decrement = decrement_q;
  assign btn_level = btn_level_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_debounce_pulser.sv
// Bench for debounce_pulser: directed scenarios plus random bouncing input,
// all cycles compared against a run-length model of the debounce rules.
module tb_debounce_pulser;
  import debounce_pkg::*;

  localparam int D   = 4;
  localparam int H   = 8;
  localparam int R   = 3;
  localparam int REP = 1;

  // clock / reset
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  debounce_pulser_if bus();
  db_state_e dut_state;

  debounce_pulser #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .REPEAT_EN       (REP)
  ) dut (
    .clk       (clk),
    .reset     (reset_n),
    .btn_in    (bus.btn_in),
    .enable    (bus.enable),
    .decrement (bus.decrement),
    .btn_level (bus.btn_level),
    .state_o   (dut_state)
  );

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  // reference model: sync pipe plus run lengths of the synchronized level
  logic m_s1, m_s2, m_lvl, m_dec;
  int   m_run, m_n, m_z;

  int   edge_no, pulse_cnt, first_pulse_edge, chain_cnt;
  logic prev_dec_obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_dec = 1'b0;
    m_run = 0; m_n = 0; m_z = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic sample, pulse;
    sample = m_s2;
    m_s2   = m_s1;
    m_s1   = bus.btn_in;
    pulse  = 1'b0;
    if (!m_lvl) begin
      if (sample) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = 1'b1; pulse = 1'b1; m_n = 0; m_z = 0; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (sample) begin
        if (m_z > 0) begin
          m_z = 0; m_n = 0;
        end else begin
          m_n++;
          if (REP != 0 && m_n >= H && ((m_n - H) % R) == 0) pulse = 1'b1;
        end
      end else begin
        m_z++;
        if (m_z == D + 1) begin
          m_lvl = 1'b0; m_z = 0; m_run = 0;
        end
      end
    end
    m_dec = pulse && bus.enable && !m_dec;
    exp_q.push_back({m_dec, m_lvl});
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic tick(input logic b, input logic e);
    logic [1:0] exp_v;
    bus.btn_in = b;
    bus.enable = e;
    @(posedge clk);
    model_step();
    #1;
    exp_v = exp_q.pop_front();
    check("decrement", 32'(bus.decrement), 32'(exp_v[1]));
    check("btn_level", 32'(bus.btn_level), 32'(exp_v[0]));
    if (prev_dec_obs) check("no_back_to_back", 32'(bus.decrement), 32'd0);
    edge_no++;
    if (bus.decrement) begin
      pulse_cnt++;
      if (first_pulse_edge == 0) first_pulse_edge = edge_no;
      if (chain_cnt != 0) chain_cnt--;
    end
    prev_dec_obs = bus.decrement;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_decrement", 32'(bus.decrement), 32'd0);
    check("rst_btn_level", 32'(bus.btn_level), 32'd0);
    check("rst_state", 32'(dut_state), 32'(ST_IDLE));
    model_reset();
    prev_dec_obs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic mark();
    edge_no = 0; pulse_cnt = 0; first_pulse_edge = 0;
  endtask

  task automatic release_btn();
    repeat (12) tick(1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] bounce_pat;
    bus.btn_in = 1'b0;
    bus.enable = 1'b1;
    chain_cnt = 0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // clean press held 10 cycles
    mark();
    repeat (10) tick(1'b1, 1'b1);
    check("clean_first_edge", first_pulse_edge, 7);
    check("clean_pulses", pulse_cnt, 1);
    check("clean_level", 32'(bus.btn_level), 32'd1);
    release_btn();
    check("clean_released", 32'(bus.btn_level), 32'd0);

    // bounce 1,1,0 then steady high
    bounce_pat = 14'b11111111111011;
    mark();
    for (int i = 0; i < 14; i++) tick(bounce_pat[i], 1'b1);
    check("bounce_first_edge", first_pulse_edge, 10);
    check("bounce_pulses", pulse_cnt, 1);
    release_btn();

    // long hold with auto-repeat
    mark();
    repeat (30) tick(1'b1, 1'b1);
    release_btn();
    check("hold_first_edge", first_pulse_edge, 7);
    check("hold_pulses", pulse_cnt, 7);

    // enable low across the accept edge
    mark();
    repeat (8) tick(1'b1, 1'b0);
    repeat (4) tick(1'b1, 1'b1);
    check("en_pulses", pulse_cnt, 0);
    check("en_level", 32'(bus.btn_level), 32'd1);
    release_btn();

    // reset in the middle of press debounce
    mark();
    repeat (4) tick(1'b1, 1'b1);
    apply_reset();
    mark();
    repeat (10) tick(1'b1, 1'b1);
    check("rst_press_first_edge", first_pulse_edge, 7);
    check("rst_press_pulses", pulse_cnt, 1);
    release_btn();

    // three presses into a 4-bit down counter loaded with 4
    chain_cnt = 4;
    repeat (3) begin
      repeat (9) tick(1'b1, 1'b1);
      release_btn();
    end
    check("chain_count", chain_cnt, 1);

    // random bouncing segments, random enable, occasional reset
    for (int s = 0; s < 300; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) apply_reset();
      for (int k = 0; k < len; k++) tick(lvl, 1'($urandom_range(0, 3) != 0));
    end
    release_btn();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
